// File: rtl/peripheral_dbg_pu_riscv_jsp_biu_arbiter.sv
// rtl/peripheral_dbg_pu_riscv_jsp_biu_arbiter.sv - round-robin burst arbiter in front of the JSP BIU byte port
module peripheral_dbg_pu_riscv_jsp_biu_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int SETTLE_CYC = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 tck_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ-1:0]   req_we_i,
  input  logic [NUM_REQ*4-1:0] req_len_i,
  input  logic [NUM_REQ*8-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [NUM_REQ-1:0]   wdata_ack_o,
  output logic [7:0]           rdata_o,
  output logic [NUM_REQ-1:0]   rdata_vld_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic [NUM_REQ-1:0]   err_o,
  output logic [7:0]           biu_di_o,
  input  logic [7:0]           biu_do_i,
  input  logic [3:0]           biu_bytes_available_i,
  input  logic [3:0]           biu_space_available_i,
  output logic                 biu_rd_strobe_o,
  output logic                 biu_wr_strobe_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_XFER   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 arb_q, arb_d;        // burst latched in IDLE, grant goes out next edge
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 we_q, we_d;
  logic [3:0]           len_q, len_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [SW-1:0]        set_q, set_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   vld_q, vld_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic [7:0]           rdata_q, rdata_d;
  logic [7:0]           di_q, di_d;
  logic                 rd_stb_q, rd_stb_d;
  logic                 wr_stb_q, wr_stb_d;

  logic [IW-1:0]        pick_idx;
  logic                 pick_vld;
  int                   pick_pos;
  logic [NUM_REQ-1:0]   idx_oh;
  logic                 xfer_ok;

  assign idx_oh  = NUM_REQ'(1) << idx_q;
  assign xfer_ok = we_q ? (biu_space_available_i != 4'd0) : (biu_bytes_available_i != 4'd0);

  // Round-robin search: first pending request at or after rr_ptr, wrapping
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    pick_pos = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pick_pos = int'(rr_ptr_q) + k;
      if (pick_pos >= NUM_REQ) pick_pos = pick_pos - NUM_REQ;
      if (!pick_vld && req_i[pick_pos]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(pick_pos);
      end
    end
  end

  // Burst sequencer: next state plus one-cycle strobe/ack/vld/done pulses
  always_comb begin
    state_d  = state_q;
    arb_d    = arb_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    we_d     = we_q;
    len_d    = len_q;
    tmo_d    = tmo_q;
    set_d    = set_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    vld_d    = '0;
    done_d   = '0;
    err_d    = '0;
    rdata_d  = 8'h00;
    di_d     = 8'h00;
    rd_stb_d = 1'b0;
    wr_stb_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_q) begin
          arb_d = 1'b0;
          gnt_d = idx_oh;
          tmo_d = '0;
          if (len_q == 4'd0) begin
            state_d = ST_DONE;
            done_d  = idx_oh;
          end else begin
            state_d = ST_XFER;
          end
        end else if (pick_vld) begin
          arb_d = 1'b1;
          idx_d = pick_idx;
          we_d  = req_we_i[pick_idx];
          len_d = req_len_i[4*int'(pick_idx) +: 4];
        end
      end
      ST_XFER: begin
        if (xfer_ok) begin
          if (we_q) begin
            wr_stb_d = 1'b1;
            di_d     = req_wdata_i[8*int'(idx_q) +: 8];
            ack_d    = idx_oh;
          end else begin
            rd_stb_d = 1'b1;
            rdata_d  = biu_do_i;
            vld_d    = idx_oh;
          end
          if (len_q != 4'd0) len_d = len_q - 4'd1;
          tmo_d   = '0;
          set_d   = SW'(SETTLE_CYC - 1);
          state_d = ST_SETTLE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_DONE;
          done_d  = idx_oh;
          err_d   = idx_oh;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        // give the BIU's clock-crossed counts time to catch up before re-sampling
        if (set_q == '0) begin
          if (len_q == 4'd0) begin
            state_d = ST_DONE;
            done_d  = idx_oh;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          set_d = set_q - 1'b1;
        end
      end
      ST_DONE: begin
        gnt_d    = '0;
        rr_ptr_d = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any burst without a done pulse
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      arb_q    <= 1'b0;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      len_q    <= 4'd0;
      tmo_q    <= '0;
      set_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      vld_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rdata_q  <= 8'h00;
      di_q     <= 8'h00;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      arb_q    <= arb_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      len_q    <= len_d;
      tmo_q    <= tmo_d;
      set_q    <= set_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      di_q     <= di_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
    end
  end

  assign gnt_o           = gnt_q;
  assign wdata_ack_o     = ack_q;
  assign rdata_vld_o     = vld_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign rdata_o         = rdata_q;
  assign biu_di_o        = di_q;
  assign biu_rd_strobe_o = rd_stb_q;
  assign biu_wr_strobe_o = wr_stb_q;

endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_jsp_biu_arbiter.sv
// tb/tb_peripheral_dbg_pu_riscv_jsp_biu_arbiter.sv - randomized self-checking bench for the JSP BIU arbiter
module tb_peripheral_dbg_pu_riscv_jsp_biu_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int SETTLE_CYC = 2;
  localparam int TIMEOUT    = 1024;

  logic                 tck_i = 1'b0;
  logic                 rst_i;
  logic [NUM_REQ-1:0]   req_i;
  logic [NUM_REQ-1:0]   req_we_i;
  logic [NUM_REQ*4-1:0] req_len_i;
  logic [NUM_REQ*8-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]   gnt_o;
  logic [NUM_REQ-1:0]   wdata_ack_o;
  logic [7:0]           rdata_o;
  logic [NUM_REQ-1:0]   rdata_vld_o;
  logic [NUM_REQ-1:0]   done_o;
  logic [NUM_REQ-1:0]   err_o;
  logic [7:0]           biu_di_o;
  logic [7:0]           biu_do_i;
  logic [3:0]           biu_bytes_available_i;
  logic [3:0]           biu_space_available_i;
  logic                 biu_rd_strobe_o;
  logic                 biu_wr_strobe_o;

  peripheral_dbg_pu_riscv_jsp_biu_arbiter #(
    .NUM_REQ(NUM_REQ), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .tck_i(tck_i), .rst_i(rst_i),
    .req_i(req_i), .req_we_i(req_we_i), .req_len_i(req_len_i), .req_wdata_i(req_wdata_i),
    .gnt_o(gnt_o), .wdata_ack_o(wdata_ack_o), .rdata_o(rdata_o), .rdata_vld_o(rdata_vld_o),
    .done_o(done_o), .err_o(err_o), .biu_di_o(biu_di_o), .biu_do_i(biu_do_i),
    .biu_bytes_available_i(biu_bytes_available_i), .biu_space_available_i(biu_space_available_i),
    .biu_rd_strobe_o(biu_rd_strobe_o), .biu_wr_strobe_o(biu_wr_strobe_o)
  );

  always #5 tck_i = ~tck_i;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int mdl_rr = 0;
  int stall_left = 0;
  logic [7:0] rq[$];
  logic [7:0] wbuf [NUM_REQ][16];
  int wptr [NUM_REQ];

  function automatic int rr_pick(input logic [NUM_REQ-1:0] m, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (m[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic drive_biu();
    if (stall_left > 0) begin
      biu_bytes_available_i = 4'd0;
      biu_space_available_i = 4'd0;
    end else begin
      biu_bytes_available_i = (rq.size() > 15) ? 4'd15 : 4'(rq.size());
      biu_space_available_i = 4'd8;
    end
    biu_do_i = (rq.size() > 0) ? rq[0] : 8'h00;
  endtask

  // one cycle: outputs are stable at the negedge, then requesters/BIU react
  task automatic tick();
    @(negedge tck_i);
    cyc++;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (wdata_ack_o[r]) begin
        wptr[r]++;
        req_wdata_i[r*8 +: 8] = wbuf[r][wptr[r] & 15];
      end
    end
    if (biu_rd_strobe_o && rq.size() > 0) void'(rq.pop_front());
    if (stall_left > 0) stall_left--;
    drive_biu();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    req_i = '0; req_we_i = '0; req_len_i = '0; req_wdata_i = '0;
    for (int r = 0; r < NUM_REQ; r++) wptr[r] = 0;
    drive_biu();
    repeat (3) tick();
    vec_cnt++;
    if ({gnt_o, wdata_ack_o, rdata_vld_o, done_o, err_o, rdata_o, biu_di_o, biu_rd_strobe_o, biu_wr_strobe_o} !== '0) begin
      err_cnt++;
      $display("FAIL reset_hold: gnt=%b ack=%b vld=%b done=%b err=%b rd=%b wr=%b, all required 0",
               gnt_o, wdata_ack_o, rdata_vld_o, done_o, err_o, biu_rd_strobe_o, biu_wr_strobe_o);
    end
    rst_i = 1'b0;
    mdl_rr = 0;
    repeat (3) tick();
    vec_cnt++;
    if ({gnt_o, done_o, biu_rd_strobe_o, biu_wr_strobe_o} !== '0) begin
      err_cnt++;
      $display("FAIL reset_idle: gnt=%b done=%b rd=%b wr=%b, all required 0",
               gnt_o, done_o, biu_rd_strobe_o, biu_wr_strobe_o);
    end
  endtask

  task automatic test_burst(input int r, input bit we, input int len, input int s);
    logic [7:0] exp_q[$];
    logic [NUM_REQ-1:0] oh, exp_g;
    logic [7:0] b;
    int n0, k, nstb, last_k, exp_k;
    bit seen_done, ok;
    oh = NUM_REQ'(1) << r;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      if (we) wbuf[r][i] = b; else rq.push_back(b);
    end
    wptr[r] = 0;
    req_wdata_i[r*8 +: 8] = wbuf[r][0];
    req_we_i[r] = we;
    req_len_i[r*4 +: 4] = 4'(len);
    stall_left = s;
    drive_biu();
    req_i[r] = 1'b1;
    n0 = cyc; nstb = 0; last_k = 0; seen_done = 1'b0;
    for (int t = 0; t < 200 && !seen_done; t++) begin
      tick();
      k = cyc - n0;
      exp_g = (k >= 2) ? oh : '0;
      vec_cnt++;
      if (gnt_o !== exp_g) begin
        err_cnt++;
        $display("FAIL burst_gnt r=%0d k=%0d: gnt_o=%b required %b", r, k, gnt_o, exp_g);
      end
      if (biu_wr_strobe_o || biu_rd_strobe_o) begin
        exp_k = (nstb == 0) ? 3 + ((s > 2) ? s - 2 : 0) : last_k + SETTLE_CYC + 1;
        vec_cnt++;
        if (k != exp_k || nstb >= len) begin
          err_cnt++;
          $display("FAIL burst_strobe_time r=%0d byte=%0d: at cycle %0d required %0d (len %0d)", r, nstb, k, exp_k, len);
        end
        if (nstb < len) begin
          if (we) ok = biu_wr_strobe_o && !biu_rd_strobe_o && biu_di_o === exp_q[nstb] && wdata_ack_o === oh && rdata_vld_o === '0;
          else    ok = biu_rd_strobe_o && !biu_wr_strobe_o && rdata_o === exp_q[nstb] && rdata_vld_o === oh && wdata_ack_o === '0;
          vec_cnt++;
          if (!ok) begin
            err_cnt++;
            $display("FAIL burst_data r=%0d we=%0d byte=%0d: wr=%b rd=%b di=%h rdata=%h ack=%b vld=%b required byte %h mask %b",
                     r, we, nstb, biu_wr_strobe_o, biu_rd_strobe_o, biu_di_o, rdata_o, wdata_ack_o, rdata_vld_o, exp_q[nstb], oh);
          end
        end
        last_k = k;
        nstb++;
      end else begin
        vec_cnt++;
        if ((wdata_ack_o | rdata_vld_o) !== '0) begin
          err_cnt++;
          $display("FAIL burst_stray_pulse r=%0d k=%0d: ack=%b vld=%b required 0", r, k, wdata_ack_o, rdata_vld_o);
        end
      end
      if (done_o !== '0) begin
        exp_k = (len == 0) ? 2 : last_k + SETTLE_CYC;
        vec_cnt++;
        if (done_o !== oh || err_o !== '0 || nstb != len || k != exp_k) begin
          err_cnt++;
          $display("FAIL burst_done r=%0d: done=%b err=%b bytes=%0d cycle=%0d required done=%b err=0 bytes=%0d cycle=%0d",
                   r, done_o, err_o, nstb, k, oh, len, exp_k);
        end
        req_i[r] = 1'b0;
        seen_done = 1'b1;
        mdl_rr = (r + 1) % NUM_REQ;
      end
    end
    if (!seen_done) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL burst_timeout r=%0d: no done_o within 200 cycles, required done", r);
      req_i[r] = 1'b0;
    end
    tick();
    vec_cnt++;
    if (gnt_o !== '0 || done_o !== '0) begin
      err_cnt++;
      $display("FAIL burst_release r=%0d: gnt=%b done=%b required 0", r, gnt_o, done_o);
    end
    rq.delete();
  endtask

  task automatic test_round_robin_pair();
    logic [NUM_REQ-1:0] m, oh;
    int exp_i;
    bit got;
    m = 4'b0101;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_we_i[r] = 1'b1;
      req_len_i[r*4 +: 4] = 4'd1;
      wbuf[r][0] = 8'($urandom);
      wptr[r] = 0;
      req_wdata_i[r*8 +: 8] = wbuf[r][0];
    end
    stall_left = 0;
    drive_biu();
    req_i = m;
    for (int g = 0; g < 4; g++) begin
      exp_i = rr_pick(m, mdl_rr);
      oh = NUM_REQ'(1) << exp_i;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        tick();
        if (gnt_o !== '0) got = 1'b1;
      end
      vec_cnt++;
      if (gnt_o !== oh) begin
        err_cnt++;
        $display("FAIL rr_pair_grant %0d: gnt_o=%b required %b", g, gnt_o, oh);
      end
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        vec_cnt++;
        if ($countones(gnt_o) > 1) begin
          err_cnt++;
          $display("FAIL rr_pair_onehot: gnt_o=%b required at most one bit", gnt_o);
        end
        if (done_o !== '0) got = 1'b1;
        else tick();
      end
      vec_cnt++;
      if (done_o !== oh) begin
        err_cnt++;
        $display("FAIL rr_pair_done %0d: done_o=%b required %b", g, done_o, oh);
      end
      mdl_rr = (exp_i + 1) % NUM_REQ;
      if (g == 3) req_i = '0;
    end
    tick();
  endtask

  task automatic test_timeout();
    logic [NUM_REQ-1:0] oh;
    int xfer_cyc;
    bit got, stb;
    oh = 4'b1000;
    wbuf[3][0] = 8'h5A;
    wptr[3] = 0;
    req_wdata_i[3*8 +: 8] = 8'h5A;
    req_we_i[3] = 1'b1;
    req_len_i[3*4 +: 4] = 4'd1;
    stall_left = 1 << 20;
    drive_biu();
    req_i[3] = 1'b1;
    xfer_cyc = 0; got = 1'b0; stb = 1'b0;
    for (int t = 0; t < TIMEOUT + 50 && !got; t++) begin
      tick();
      if (biu_wr_strobe_o || biu_rd_strobe_o) stb = 1'b1;
      if (done_o !== '0) got = 1'b1;
      else if (gnt_o !== '0) xfer_cyc++;
    end
    vec_cnt++;
    if (!got || done_o !== oh || err_o !== oh || stb) begin
      err_cnt++;
      $display("FAIL timeout_done: seen=%0d done=%b err=%b strobe=%0d required done=err=%b no strobe", got, done_o, err_o, stb, oh);
    end
    vec_cnt++;
    if (xfer_cyc != TIMEOUT) begin
      err_cnt++;
      $display("FAIL timeout_length: %0d waiting cycles required %0d", xfer_cyc, TIMEOUT);
    end
    req_i[3] = 1'b0;
    mdl_rr = 0;
    tick();
    vec_cnt++;
    if (done_o !== '0 || err_o !== '0 || gnt_o !== '0) begin
      err_cnt++;
      $display("FAIL timeout_pulse: done=%b err=%b gnt=%b required 0 one cycle later", done_o, err_o, gnt_o);
    end
    stall_left = 0;
    drive_biu();
  endtask

  task automatic test_contention(input int rounds);
    logic [NUM_REQ-1:0] m, oh;
    int exp_i, n0;
    bit got;
    for (int i = 0; i < rounds; i++) begin
      m = 4'($urandom_range(1, 15));
      for (int r = 0; r < NUM_REQ; r++) begin
        req_we_i[r] = 1'($urandom);
        req_len_i[r*4 +: 4] = 4'd0;
      end
      exp_i = rr_pick(m, mdl_rr);
      oh = NUM_REQ'(1) << exp_i;
      req_i = m;
      n0 = cyc;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        tick();
        if (gnt_o !== '0) got = 1'b1;
      end
      vec_cnt++;
      if (gnt_o !== oh || done_o !== oh || cyc - n0 != 2) begin
        err_cnt++;
        $display("FAIL contention_grant mask=%b rr=%0d: gnt=%b done=%b cycle=%0d required %b at cycle 2",
                 m, mdl_rr, gnt_o, done_o, cyc - n0, oh);
      end
      req_i = '0;
      mdl_rr = (exp_i + 1) % NUM_REQ;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [NUM_REQ-1:0] oh;
    int n0, exp_i;
    bit got;
    test_burst(1, 1'b1, 1, 0);
    for (int i = 0; i < 5; i++) wbuf[2][i] = 8'($urandom);
    wptr[2] = 0;
    req_wdata_i[2*8 +: 8] = wbuf[2][0];
    req_we_i[2] = 1'b1;
    req_len_i[2*4 +: 4] = 4'd5;
    req_i[2] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      tick();
      if (biu_wr_strobe_o) got = 1'b1;
    end
    vec_cnt++;
    if (!got) begin
      err_cnt++;
      $display("FAIL reset_mid_start: no write strobe seen, required one");
    end
    rst_i = 1'b1;
    #1;
    vec_cnt++;
    if ({gnt_o, wdata_ack_o, rdata_vld_o, done_o, err_o, rdata_o, biu_di_o, biu_rd_strobe_o, biu_wr_strobe_o} !== '0) begin
      err_cnt++;
      $display("FAIL reset_mid_outputs: gnt=%b ack=%b done=%b di=%h wr=%b, all required 0",
               gnt_o, wdata_ack_o, done_o, biu_di_o, biu_wr_strobe_o);
    end
    req_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
    mdl_rr = 0;
    tick();
    req_len_i[0 +: 4] = 4'd0;
    req_len_i[3*4 +: 4] = 4'd0;
    req_i = 4'b1001;
    exp_i = rr_pick(4'b1001, mdl_rr);
    oh = NUM_REQ'(1) << exp_i;
    n0 = cyc;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      tick();
      if (gnt_o !== '0) got = 1'b1;
    end
    vec_cnt++;
    if (gnt_o !== oh || cyc - n0 != 2) begin
      err_cnt++;
      $display("FAIL reset_mid_rr: gnt=%b at cycle %0d required %b at cycle 2", gnt_o, cyc - n0, oh);
    end
    req_i = '0;
    mdl_rr = (exp_i + 1) % NUM_REQ;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin_pair();
    test_burst(1, 1'b1, 3, 0);
    test_burst(0, 1'b0, 2, 10);
    test_timeout();
    test_burst(2, 1'b1, 0, 0);
    test_burst(3, 1'b0, 0, 0);
    for (int i = 0; i < 12; i++)
      test_burst($urandom_range(0, NUM_REQ - 1), 1'($urandom), $urandom_range(1, 15), $urandom_range(0, 6));
    test_contention(10);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
